// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the parameterised ALU: accepts an op request, holds the ALU
// inputs for one settle cycle, then returns the captured result on a response handshake.
module alu_op_sequencer #(
  parameter int         Ancho = 4,
  parameter logic [3:0] MaxOp = 4'h9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [Ancho-1:0] req_a,
  input  logic [Ancho-1:0] req_b,
  input  logic [3:0]       req_op,
  input  logic             req_flag_in,
  input  logic             req_chain,
  output logic [Ancho-1:0] alu_a,
  output logic [Ancho-1:0] alu_b,
  output logic [3:0]       alu_control,
  output logic             alu_flag_in,
  input  logic [Ancho-1:0] alu_result,
  input  logic             alu_flags,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Ancho-1:0] rsp_result,
  output logic             rsp_flags,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [7:0]       op_count
);

  // state | meaning
  // IDLE  | ready for a request
  // DRIVE | ALU inputs held for one settle cycle, result captured at its end
  // RESP  | response presented until the consumer takes it
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t           state_q, state_d;
  logic [Ancho-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_ctl_q, alu_ctl_d;
  logic             alu_fin_q, alu_fin_d;
  logic [Ancho-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_flags_q, rsp_flags_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic [Ancho-1:0] last_result_q, last_result_d;
  logic             last_valid_q, last_valid_d;
  logic [7:0]       op_count_q, op_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctl_q     <= '0;
      alu_fin_q     <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      last_result_q <= '0;
      last_valid_q  <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctl_q     <= alu_ctl_d;
      alu_fin_q     <= alu_fin_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_err_q     <= rsp_err_d;
      last_result_q <= last_result_d;
      last_valid_q  <= last_valid_d;
      op_count_q    <= op_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctl_d     = alu_ctl_q;
    alu_fin_d     = alu_fin_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_err_d     = rsp_err_q;
    last_result_d = last_result_q;
    last_valid_d  = last_valid_q;
    op_count_d    = op_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_op <= MaxOp) begin
            // A chained op with no prior result feeds zero rather than stale data
            if (req_chain) alu_a_d = last_valid_q ? last_result_q : '0;
            else           alu_a_d = req_a;
            alu_b_d   = req_b;
            alu_ctl_d = req_op;
            alu_fin_d = req_flag_in;
            state_d   = DRIVE;
          end else begin
            rsp_result_d = '0;
            rsp_flags_d  = 1'b0;
            rsp_zero_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = RESP;
          end
        end
      end
      DRIVE: begin
        rsp_result_d  = alu_result;
        rsp_flags_d   = alu_flags;
        rsp_zero_d    = alu_z;
        rsp_err_d     = 1'b0;
        last_result_d = alu_result;
        last_valid_d  = 1'b1;
        op_count_d    = op_count_q + 8'd1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctl_q;
  assign alu_flag_in = alu_fin_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an XOR ALU stub: result=A^B, flags=ALUFlagIn, Z=(result==0).
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_a = '0, req_b = '0, req_op = '0;
  logic       req_flag_in = 1'b0, req_chain = 1'b0;
  logic [3:0] alu_a, alu_b, alu_control;
  logic       alu_flag_in;
  logic [3:0] alu_result;
  logic       alu_flags, alu_z;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_result;
  logic       rsp_flags, rsp_zero, rsp_err;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;

  assign alu_result = alu_a ^ alu_b;
  assign alu_flags  = alu_flag_in;
  assign alu_z      = (alu_result == 4'd0);

  always #5 clk = ~clk;

  alu_op_sequencer #(.Ancho(4), .MaxOp(4'h9)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_flag_in(req_flag_in), .req_chain(req_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_flag_in(alu_flag_in),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                           input logic fin, input logic chain);
    req_valid   = 1'b1;
    req_a       = a;
    req_b       = b;
    req_op      = op;
    req_flag_in = fin;
    req_chain   = chain;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if ({alu_a, alu_b, alu_control, alu_flag_in} !== 13'd0) begin errors++;
      $display("FAIL reset_alu_outputs got=%h/%h/%h/%b exp=0", alu_a, alu_b, alu_control, alu_flag_in); end
    checks++; if ({rsp_result, rsp_flags, rsp_zero, rsp_err} !== 7'd0) begin errors++;
      $display("FAIL reset_rsp_fields got=%h/%b/%b/%b exp=0", rsp_result, rsp_flags, rsp_zero, rsp_err); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL after_release got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid); end
  endtask

  task automatic test_single_op();
    do_reset();
    drive_req(4'b0110, 4'b0010, 4'h3, 1'b1, 1'b0);
    tick();
    req_valid = 1'b0;
    checks++; if ({alu_a, alu_b, alu_control, alu_flag_in} !== {4'b0110, 4'b0010, 4'h3, 1'b1}) begin errors++;
      $display("FAIL single_drive got=%b/%b/%h/%b exp=0110/0010/3/1", alu_a, alu_b, alu_control, alu_flag_in); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++;
      $display("FAIL single_drive_hs got valid=%b ready=%b exp 0/0", rsp_valid, req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b0100 || rsp_flags !== 1'b1 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL single_resp got v=%b r=%b f=%b z=%b e=%b exp v=1 r=0100 f=1 z=0 e=0", rsp_valid, rsp_result, rsp_flags, rsp_zero, rsp_err); end
    checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", op_count); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL single_return got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    checks++; if (rsp_result !== 4'b0100 || alu_a !== 4'b0110) begin errors++;
      $display("FAIL single_hold got rsp=%b alu_a=%b exp rsp=0100 alu_a=0110", rsp_result, alu_a); end
  endtask

  task automatic test_chain();
    do_reset();
    drive_req(4'b1010, 4'b0000, 4'h0, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    tick();
    checks++; if (rsp_result !== 4'b1010 || rsp_zero !== 1'b0) begin errors++;
      $display("FAIL chain_op1 got r=%b z=%b exp r=1010 z=0", rsp_result, rsp_zero); end
    tick();
    drive_req(4'b1111, 4'b1010, 4'h0, 1'b0, 1'b1);
    tick(); req_valid = 1'b0;
    checks++; if (alu_a !== 4'b1010) begin errors++; $display("FAIL chain_alu_a got=%b exp=1010", alu_a); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b0000 || rsp_zero !== 1'b1 || op_count !== 8'd2) begin errors++;
      $display("FAIL chain_op2 got v=%b r=%b z=%b cnt=%0d exp v=1 r=0000 z=1 cnt=2", rsp_valid, rsp_result, rsp_zero, op_count); end
    tick();
  endtask

  // Runs after test_chain: ALU outputs are a=1010 b=1010 ctl=0 fin=0, count=2
  task automatic test_illegal();
    drive_req(4'b0011, 4'b0101, 4'hC, 1'b1, 1'b0);
    tick(); req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 4'd0 || rsp_flags !== 1'b0 || rsp_zero !== 1'b0) begin errors++;
      $display("FAIL illegal_resp got v=%b e=%b r=%b f=%b z=%b exp v=1 e=1 r=0000 f=0 z=0", rsp_valid, rsp_err, rsp_result, rsp_flags, rsp_zero); end
    checks++; if ({alu_a, alu_b, alu_control, alu_flag_in} !== {4'b1010, 4'b1010, 4'h0, 1'b0}) begin errors++;
      $display("FAIL illegal_alu_hold got=%b/%b/%h/%b exp=1010/1010/0/0", alu_a, alu_b, alu_control, alu_flag_in); end
    checks++; if (op_count !== 8'd2) begin errors++; $display("FAIL illegal_count got=%0d exp=2", op_count); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL illegal_return got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_op_boundary();
    drive_req(4'b0001, 4'b0010, 4'h9, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || alu_control !== 4'h9) begin errors++;
      $display("FAIL maxop_drive got v=%b ctl=%h exp v=0 ctl=9", rsp_valid, alu_control); end
    tick();
    checks++; if (rsp_err !== 1'b0 || rsp_result !== 4'b0011 || op_count !== 8'd3) begin errors++;
      $display("FAIL maxop_resp got e=%b r=%b cnt=%0d exp e=0 r=0011 cnt=3", rsp_err, rsp_result, op_count); end
    tick();
    drive_req(4'b0001, 4'b0010, 4'hA, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || alu_control !== 4'h9 || op_count !== 8'd3) begin errors++;
      $display("FAIL above_maxop got v=%b e=%b ctl=%h cnt=%0d exp v=1 e=1 ctl=9 cnt=3", rsp_valid, rsp_err, alu_control, op_count); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    drive_req(4'b0011, 4'b0101, 4'h1, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b0110) begin errors++;
      $display("FAIL bp_first got v=%b r=%b exp v=1 r=0110", rsp_valid, rsp_result); end
    drive_req(4'b1111, 4'b0000, 4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 4'b0110 || rsp_err !== 1'b0 || alu_a !== 4'b0011 || alu_b !== 4'b0101) begin errors++;
        $display("FAIL bp_hold cycle=%0d got v=%b rdy=%b r=%b e=%b a=%b b=%b exp v=1 rdy=0 r=0110 e=0 a=0011 b=0101",
                 i, rsp_valid, req_ready, rsp_result, rsp_err, alu_a, alu_b); end
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_a !== 4'b0011) begin errors++;
      $display("FAIL bp_release got v=%b rdy=%b a=%b exp v=0 rdy=1 a=0011", rsp_valid, req_ready, alu_a); end
    tick(); req_valid = 1'b0;
    checks++; if ({alu_a, alu_b, alu_control, alu_flag_in} !== {4'b1111, 4'b0000, 4'h2, 1'b1}) begin errors++;
      $display("FAIL bp_next_drive got=%b/%b/%h/%b exp=1111/0000/2/1", alu_a, alu_b, alu_control, alu_flag_in); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b1111 || rsp_flags !== 1'b1 || op_count !== 8'd2) begin errors++;
      $display("FAIL bp_next_resp got v=%b r=%b f=%b cnt=%0d exp v=1 r=1111 f=1 cnt=2", rsp_valid, rsp_result, rsp_flags, op_count); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    drive_req(4'b0101, 4'b0000, 4'h0, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    tick(); tick();
    drive_req(4'b0110, 4'b0001, 4'h4, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    checks++; if (alu_a !== 4'b0110 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL mid_drive got a=%b v=%b exp a=0110 v=0", alu_a, rsp_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || op_count !== 8'd0 || alu_a !== 4'd0 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL mid_async got rdy=%b cnt=%0d a=%b v=%b exp rdy=1 cnt=0 a=0000 v=0", req_ready, op_count, alu_a, rsp_valid); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || op_count !== 8'd0) begin errors++;
        $display("FAIL mid_discard cycle=%0d got v=%b cnt=%0d exp v=0 cnt=0", i, rsp_valid, op_count); end
    end
    drive_req(4'b1111, 4'b0011, 4'h0, 1'b0, 1'b1);
    tick(); req_valid = 1'b0;
    checks++; if (alu_a !== 4'b0000 || alu_b !== 4'b0011) begin errors++;
      $display("FAIL mid_chain_zero got a=%b b=%b exp a=0000 b=0011", alu_a, alu_b); end
    tick();
    checks++; if (rsp_result !== 4'b0011 || op_count !== 8'd1) begin errors++;
      $display("FAIL mid_chain_resp got r=%b cnt=%0d exp r=0011 cnt=1", rsp_result, op_count); end
    tick();
  endtask

  task automatic test_count_wrap();
    logic [3:0] a;
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      a = i[3:0];
      drive_req(a, 4'b0000, 4'h5, 1'b0, 1'b0);
      tick(); req_valid = 1'b0;
      tick();
      if (i == 255) begin
        checks++; if (op_count !== 8'd255 || rsp_result !== 4'hF) begin errors++;
          $display("FAIL wrap_255 got cnt=%0d r=%h exp cnt=255 r=f", op_count, rsp_result); end
      end
      if (i == 256) begin
        checks++; if (op_count !== 8'd0 || rsp_result !== 4'h0 || rsp_zero !== 1'b1) begin errors++;
          $display("FAIL wrap_256 got cnt=%0d r=%h z=%b exp cnt=0 r=0 z=1", op_count, rsp_result, rsp_zero); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_chain();
    test_illegal();
    test_op_boundary();
    test_backpressure();
    test_reset_mid_op();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side controller for the parameterised ALU (ports A, B, ALUControl, ALUFlagIn, ALUFlags, ALUResult, Z).
- Accepts operation requests on a valid/ready channel and drives the ALU's combinational inputs for one settle cycle.
- Captures ALUResult/ALUFlags/Z into registers and returns them on a valid/ready response channel.
- Supports chained operations, where operand A comes from the previous result, and rejects undefined opcodes without driving the ALU.

Parameters:
Ancho, 4, operand/result width in bits (must match the attached ALU's Ancho)
MaxOp, 4'h9, highest legal ALUControl code; codes above it are rejected

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  Ancho  operand A (ignored when req_chain=1)
req_b  input  Ancho  operand B
req_op  input  4  ALUControl code
req_flag_in  input  1  ALUFlagIn value
req_chain  input  1  use last captured result as operand A
alu_a  output  Ancho  to ALU A
alu_b  output  Ancho  to ALU B
alu_control  output  4  to ALU ALUControl
alu_flag_in  output  1  to ALU ALUFlagIn
alu_result  input  Ancho  from ALU ALUResult
alu_flags  input  1  from ALU ALUFlags
alu_z  input  1  from ALU Z
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  Ancho  captured result
rsp_flags  output  1  captured ALUFlags
rsp_zero  output  1  captured Z
rsp_err  output  1  1 = illegal opcode, result fields forced 0
op_count  output  8  count of completed legal operations, wraps 255->0

Behaviour:
- Reset (async, immediate):
  - state=IDLE; req_ready=1; rsp_valid=0.
  - rsp_result/rsp_flags/rsp_zero/rsp_err=0.
  - alu_a/alu_b/alu_control/alu_flag_in=0; op_count=0.
  - last_result=0, last_valid=0.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at cycle T with req_op<=MaxOp:
    - register the operands onto the alu_* outputs. alu_a = last_result if req_chain=1 and last_valid=1; alu_a = 0 if req_chain=1 and last_valid=0; otherwise alu_a = req_a.
    - Next state DRIVE at T+1.
  - On req_valid with req_op>MaxOp:
    - alu_* outputs hold their previous values.
    - rsp_err=1, rsp_result/flags/zero=0, last_result/last_valid and op_count unchanged.
    - Next state RESP, so rsp_valid=1 at T+1.
- DRIVE (exactly 1 cycle):
  - req_ready=0; alu_* outputs stable for the ALU to settle.
  - At the clock edge ending DRIVE: capture alu_result/alu_flags/alu_z into rsp_*, set rsp_err=0, last_result=alu_result, last_valid=1, op_count+=1.
  - Next state RESP, so rsp_valid=1 at T+2.
- RESP:
  - req_ready=0; rsp_valid=1; all rsp_* held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready, return to IDLE next cycle (rsp_valid=0, req_ready=1).
  - No request is accepted in the handshake cycle, so minimum initiation interval is 3 cycles for legal ops and 2 for illegal ops.
- alu_* outputs keep their last driven values outside DRIVE (no glitching back to 0); they change only when a legal request is accepted.
- rsp_* values remain readable after rsp_valid drops, until overwritten.
- Widths:
  - All operand paths are Ancho bits, with no extension or truncation inside the block.
  - op_count is 8-bit modulo and does not count rejected ops.
- req_* inputs are sampled only in the acceptance cycle; changes during DRIVE/RESP have no effect.
- rsp_ready held high continuously: each response lasts exactly 1 cycle.
- rst asserted in DRIVE or RESP: immediate return to reset values; the pending response is discarded and the in-flight op is not counted.

Test Plan:
Bench attaches an ALU stub with ALUResult=A^B, ALUFlags=ALUFlagIn, Z=(ALUResult==0).
- Reset: after rst release → req_ready=1, rsp_valid=0, op_count=0, alu_* outputs 0.
- Single op: req a=4'b0110, b=4'b0010, op=4'h3, flag_in=1 at T, rsp_ready=1 →
  - alu_a=0110, alu_b=0010, alu_control=3 from T+1.
  - rsp_valid at T+2 only, with rsp_result=0100, rsp_flags=1, rsp_zero=0, rsp_err=0, op_count=1.
- Chain and zero:
  - Op1 a=4'b1010, b=4'b0000 → result 1010.
  - Op2 with req_chain=1, req_a=4'b1111, b=4'b1010 → alu_a=1010, result 0000, rsp_zero=1, op_count=2.
- Illegal opcode: req op=4'hC → rsp_valid at T+1, rsp_err=1, rsp_result=0, alu_* unchanged, op_count unchanged.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req_ready=0, and a new req_valid is ignored. After rsp_ready=1 for one cycle → IDLE, next request accepted.
- Reset mid-op: assert rst during DRIVE → rsp_valid never rises, op_count=0, and the next request sees last_valid=0, so a chained request drives alu_a=0.
